source_injection_arbiter: RTL and testbench
===========================================

# source_injection_arbiter

Round-robin arbiter that shares one router local injection port among `NSRC` memory-driven traffic sources. It grants one source at a time through that source's `send`/`busy` pair and captures the resulting one-cycle `req`/`data` beat. It then forwards the beat to the router as a one-cycle `net_req` and enforces a minimum injection gap of `PIR` cycles. It sits between a node's traffic sources and the router's local input.

## Interface
- `NSRC`, 4: number of sources; must be ≥2.
- `WIN`, 4: maximum grant window in cycles; must be ≥2.
- `PIR`, 16: gap cycles after each injection; range 1–255.
- `W`: fixed at `` `PAYLOAD_SIZE+`ADDR_BITS ``; not overridable.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `src_en`  in  NSRC  per-source enable mask.
- `src_req`  in  NSRC  per-source one-cycle request.
- `src_data`  in  NSRC*W  source i occupies bits [i*W +: W].
- `src_send`  out  NSRC  per-source grant.
- `src_busy`  out  NSRC  per-source hold-off.
- `net_req`  out  1  one-cycle injection strobe to the router.
- `net_data`  out  W  injected flit; payload (source id) on the upper bits, destination on the low `` `ADDR_BITS ``.
- `net_busy`  in  1  router local port not ready.

## Operation
- FSM states: IDLE, GRANT, GAP. Registers:
  - `g`: granted index.
  - `ptr`: round-robin start.
  - `wcnt`: window counter.
  - `gcnt`: 8-bit gap counter.
- **IDLE**
  - If `!net_busy` and any `src_en` bit is set: select the first enabled index at or after `ptr` (wrapping at NSRC-1→0), register it into `g`, load `wcnt`=WIN-1, go to GRANT.
  - Otherwise remain in IDLE.
- **GRANT**
  - Drive `src_send[g]`=1 and `src_busy[g]`=`net_busy`.
  - On each edge:
    - If `src_req[g]`=1: `net_req`<=1, `net_data`<=`src_data[g]`, `gcnt`<=PIR-1, `ptr`<=(g+1) mod NSRC, go to GAP.
    - Else if `wcnt`=0: timeout; `ptr`<=(g+1) mod NSRC, go to IDLE.
    - Else `wcnt`<=`wcnt`-1.
- **GAP**
  - `net_req`<=0 after its single cycle.
  - If `gcnt`=0, go to IDLE; else `gcnt`<=`gcnt`-1.
- Outputs in every state:
  - `src_send[i]`=(state==GRANT && g==i), combinational from registered state.
  - `src_busy[i]`=1 for all non-granted sources and in all states other than GRANT.
- Requests on `src_req[i]` with i≠g, or any request outside GRANT, are ignored. Data is not captured.
- `src_en[g]` dropping during GRANT does not abort the grant.
- Reset values:
  - state=IDLE, `g`=0, `ptr`=0, `wcnt`=0, `gcnt`=0.
  - `net_req`=0, `net_data`=0.
  - `src_send`=0, `src_busy`=all ones.
- Reset asserted mid-grant or mid-gap forces reset values immediately. The in-flight beat is lost.

## Timing
- Let E0 be the edge on which GRANT is entered.
  - `src_send[g]` is high in the cycle after E0.
  - A source with a registered `req` responds one edge later.
  - `net_req` rises on the following edge.
  - Minimum grant-to-inject latency: 2 edges after E0.
- `net_req` is high for exactly 1 cycle. `net_data` holds until the next capture.
- Minimum spacing between consecutive `net_req` rising edges: PIR+3 cycles.
- A timed-out grant occupies WIN cycles in GRANT and 1 cycle in IDLE.
- A request sampled on the same edge as `wcnt`=0 is accepted; the request takes priority over the timeout.
- `net_busy` is sampled only in IDLE (gate to grant) and combinationally onto `src_busy[g]` in GRANT. It does not abort a captured beat.

## Configuration
- `ARB_STATS_EN` defined: adds three outputs, each reset to 0 and saturating at 16'hFFFF:
  - `st_inj` (16): increments per `net_req`.
  - `st_tmo` (16): increments per grant timeout.
  - `st_drop` (16): increments once per cycle in which any ignored `src_req` bit is set.
- `ARB_STATS_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- **Reset:** hold reset 3 cycles. Expect `src_busy`=4'hF, `src_send`=0, `net_req`=0, `net_data`=0.
- **Round robin:** all four sources enabled and answering. Grants go 0,1,2,3,0. Each `net_data` upper field equals the granted id. `net_req` edges are exactly PIR+3=19 cycles apart.
- **Timeout:** `src_en`=4'b0101, source 0 never requests. Expect GRANT for 4 cycles, then a grant to source 2. With `ARB_STATS_EN`, `st_tmo`=1.
- **Illegal requests:** source 3 pulses `src_req` while source 1 is granted. Expect no capture, `net_data` taken from source 1 only. With `ARB_STATS_EN`, `st_drop`=1.
- **Back-pressure:** `net_busy`=1 for 10 cycles in IDLE. Expect no `src_send`. Grant issues 1 edge after `net_busy` falls.
- **Reset mid-operation:** assert reset during GAP with `gcnt`=5. Expect IDLE and `ptr`=0 after release. The next grant goes to source 0.

Source files
------------

// File: rtl/source_injection_arbiter.sv
// Round-robin arbiter sharing one router injection port among NSRC traffic sources,
// with a PIR-cycle injection gap. Define ARB_STATS_EN to add saturating statistics outputs.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif

module source_injection_arbiter #(
  parameter int NSRC = 4,
  parameter int WIN  = 4,
  parameter int PIR  = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NSRC-1:0]                               i_src_en,
  input  logic [NSRC-1:0]                               i_src_req,
  input  logic [NSRC*(`PAYLOAD_SIZE+`ADDR_BITS)-1:0]    i_src_data,
  output logic [NSRC-1:0]                               o_src_send,
  output logic [NSRC-1:0]                               o_src_busy,
  output logic                                          o_net_req,
  output logic [(`PAYLOAD_SIZE+`ADDR_BITS)-1:0]         o_net_data,
`ifdef ARB_STATS_EN
  output logic [15:0]                                   o_st_inj,
  output logic [15:0]                                   o_st_tmo,
  output logic [15:0]                                   o_st_drop,
`endif
  input  logic                                          i_net_busy
);

  localparam int W   = `PAYLOAD_SIZE + `ADDR_BITS;
  localparam int GW  = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_g;
  logic [GW-1:0]   r_ptr;
  logic [WCW-1:0]  r_wcnt;
  logic [7:0]      r_gcnt;
  logic            r_net_req;
  logic [W-1:0]    r_net_data;

  logic [GW-1:0]   w_sel;
  logic            w_found;
  logic [NSRC-1:0] w_onehot;
  logic            w_in_grant;
  logic            w_cap;
  logic            w_tmo;
  logic [W-1:0]    w_gdata;

  function automatic logic [GW-1:0] f_next(input logic [GW-1:0] x);
    return (x == GW'(NSRC-1)) ? '0 : x + 1'b1;
  endfunction

  // First enabled source at or after the round-robin pointer, wrapping at NSRC-1.
  always_comb begin
    logic [GW-1:0] idx;
    w_sel   = r_ptr;
    w_found = 1'b0;
    idx     = r_ptr;
    for (int k = 0; k < NSRC; k++) begin
      if (!w_found && i_src_en[idx]) begin
        w_sel   = idx;
        w_found = 1'b1;
      end
      idx = f_next(idx);
    end
  end

  assign w_in_grant = (r_state == S_GRANT);
  assign w_onehot   = NSRC'(1) << r_g;
  assign w_gdata    = i_src_data[r_g*W +: W];
  assign w_cap      = w_in_grant && i_src_req[r_g];
  assign w_tmo      = w_in_grant && !i_src_req[r_g] && (r_wcnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_g        <= '0;
      r_ptr      <= '0;
      r_wcnt     <= '0;
      r_gcnt     <= '0;
      r_net_req  <= 1'b0;
      r_net_data <= '0;
    end else begin
      r_net_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_net_busy && w_found) begin
            r_g     <= w_sel;
            r_wcnt  <= WCW'(WIN-1);
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // A request on the last window cycle still wins over the timeout.
          if (i_src_req[r_g]) begin
            r_net_req  <= 1'b1;
            r_net_data <= w_gdata;
            r_gcnt     <= 8'(PIR-1);
            r_ptr      <= f_next(r_g);
            r_state    <= S_GAP;
          end else if (r_wcnt == '0) begin
            r_ptr   <= f_next(r_g);
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt - 1'b1;
          end
        end
        S_GAP: begin
          if (r_gcnt == 8'd0) r_state <= S_IDLE;
          else                r_gcnt  <= r_gcnt - 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_src_send = w_in_grant ? w_onehot : '0;
  assign o_src_busy = w_in_grant ? (~w_onehot | ({NSRC{i_net_busy}} & w_onehot)) : '1;
  assign o_net_req  = r_net_req;
  assign o_net_data = r_net_data;

`ifdef ARB_STATS_EN
  logic [15:0]     r_st_inj;
  logic [15:0]     r_st_tmo;
  logic [15:0]     r_st_drop;
  logic [NSRC-1:0] w_ign;

  function automatic logic [15:0] f_sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  // Requests from non-granted sources, or any request outside GRANT, are dropped.
  assign w_ign = w_in_grant ? (i_src_req & ~w_onehot) : i_src_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st_inj  <= '0;
      r_st_tmo  <= '0;
      r_st_drop <= '0;
    end else begin
      if (w_cap)  r_st_inj  <= f_sat_inc(r_st_inj);
      if (w_tmo)  r_st_tmo  <= f_sat_inc(r_st_tmo);
      if (|w_ign) r_st_drop <= f_sat_inc(r_st_drop);
    end
  end

  assign o_st_inj  = r_st_inj;
  assign o_st_tmo  = r_st_tmo;
  assign o_st_drop = r_st_drop;
`endif

endmodule

// File: tb/tb_source_injection_arbiter.sv
// Bench for source_injection_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-timeline reference model.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif

module tb_source_injection_arbiter;
  localparam int NSRC = 4;
  localparam int WIN  = 4;
  localparam int PIR  = 16;
  localparam int GW   = 2;
  localparam int PB   = `PAYLOAD_SIZE;
  localparam int AB   = `ADDR_BITS;
  localparam int W    = PB + AB;

  logic              clk = 1'b0;
  logic              reset;
  logic [NSRC-1:0]   i_src_en, i_src_req, o_src_send, o_src_busy;
  logic [NSRC*W-1:0] i_src_data;
  logic              o_net_req;
  logic [W-1:0]      o_net_data;
  logic              i_net_busy;
`ifdef ARB_STATS_EN
  logic [15:0]       o_st_inj, o_st_tmo, o_st_drop;
`endif

  source_injection_arbiter #(.NSRC(NSRC), .WIN(WIN), .PIR(PIR)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_src_en   (i_src_en),
    .i_src_req  (i_src_req),
    .i_src_data (i_src_data),
    .o_src_send (o_src_send),
    .o_src_busy (o_src_busy),
    .o_net_req  (o_net_req),
    .o_net_data (o_net_data),
`ifdef ARB_STATS_EN
    .o_st_inj   (o_st_inj),
    .o_st_tmo   (o_st_tmo),
    .o_st_drop  (o_st_drop),
`endif
    .i_net_busy (i_net_busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Traffic sources: source i pulses req one cycle, dly[i] cycles after seeing its send.
  logic [NSRC-1:0] resp;
  int              dly [NSRC];
  int              scnt[NSRC];
  logic [NSRC-1:0] fix_en;
  bit              rnd_en, rnd_busy;

  // Reference timeline: grant edge, capture edge (or -1), timeout edge, next decision edge.
  bit           m_gnt;
  int           m_g, m_ptr, m_t, m_cap, m_tmo_e, m_next;
  logic [W-1:0] m_data;
  int           m_inj, m_tmo, m_drop;

  int inj_id[$];
  int inj_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_en(input logic [NSRC-1:0] en, input int p);
    for (int k = 0; k < NSRC; k++)
      if (en[GW'((p + k) % NSRC)]) return (p + k) % NSRC;
    return -1;
  endfunction

  function automatic logic [NSRC-1:0] exp_send(input int e);
    int stop;
    if (!m_gnt) return '0;
    stop = (m_cap >= 0) ? m_cap : m_t + WIN;
    return (e >= m_t && e < stop) ? (NSRC'(1) << m_g) : '0;
  endfunction

  task automatic model_edge(input int e);
    logic [NSRC-1:0] acc;
    int g;
    acc = '0;
    if (m_gnt && m_cap == e) begin
      acc[GW'(m_g)] = 1'b1;
      m_data = i_src_data[m_g*W +: W];
      m_inj++;
    end
    if (m_gnt && m_tmo_e == e) m_tmo++;
    if ((i_src_req & ~acc) != '0) m_drop++;
    if (e == m_next) begin
      g = first_en(i_src_en, m_ptr);
      if (!i_net_busy && g >= 0) begin
        m_gnt = 1'b1;
        m_g   = g;
        m_t   = e;
        m_ptr = (g + 1) % NSRC;
        if (resp[GW'(g)] && dly[g] <= WIN - 1) begin
          m_cap   = e + dly[g] + 1;
          m_tmo_e = -1;
          m_next  = m_cap + PIR + 1;
        end else begin
          m_cap   = -1;
          m_tmo_e = e + WIN;
          m_next  = e + WIN + 1;
        end
      end else begin
        m_next = e + 1;
      end
    end
  endtask

  task automatic step();
    logic [NSRC-1:0] ps, es, eb, mreq;
    int e;
    ps = o_src_send;
    e  = cyc + 1;
    model_edge(e);
    @(posedge clk);
    cyc = e;
    #1;
    for (int i = 0; i < NSRC; i++) begin
      scnt[i] = ps[i] ? scnt[i] + 1 : 0;
      mreq[i] = ps[i] && resp[i] && (scnt[i] == dly[i]);
    end
    i_src_req = mreq;
    i_src_en  = rnd_en ? NSRC'($urandom_range(0, 15)) : fix_en;
    if (rnd_busy) i_net_busy = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < NSRC; i++) i_src_data[i*W +: W] = {PB'(i), AB'($urandom)};
    #1;
    if (o_net_req) begin
      inj_id.push_back(int'(o_net_data[W-1:AB]));
      inj_cyc.push_back(cyc);
    end
    es = exp_send(cyc);
    eb = i_net_busy ? {NSRC{1'b1}} : ~es;
    chk("send", o_src_send, es);
    chk("busy", o_src_busy, eb);
    chk("net_req", o_net_req, (m_gnt && m_cap == cyc));
    chk("net_data", o_net_data, m_data);
`ifdef ARB_STATS_EN
    chk("st_inj", o_st_inj, m_inj);
    chk("st_tmo", o_st_tmo, m_tmo);
    chk("st_drop", o_st_drop, m_drop);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_send", o_src_send, 0);
    chk("rst_busy", o_src_busy, 4'hF);
    chk("rst_net_req", o_net_req, 0);
    chk("rst_net_data", o_net_data, 0);
`ifdef ARB_STATS_EN
    chk("rst_st_inj", o_st_inj, 0);
    chk("rst_st_tmo", o_st_tmo, 0);
    chk("rst_st_drop", o_st_drop, 0);
`endif
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    #2;
    i_src_req = '0;
    reset     = 1'b0;
    m_gnt = 1'b0; m_g = 0; m_ptr = 0; m_t = 0; m_cap = -1; m_tmo_e = -1;
    m_next = cyc + 1; m_data = '0; m_inj = 0; m_tmo = 0; m_drop = 0;
    for (int i = 0; i < NSRC; i++) scnt[i] = 0;
    inj_id.delete();
    inj_cyc.delete();
  endtask

  initial begin
    int  rr_exp[5];
    int  n0;
    bit  saw2, got;
    rr_exp = '{0, 1, 2, 3, 0};
    reset = 1'b1; i_src_en = '0; i_src_req = '0; i_src_data = '0; i_net_busy = 1'b0;
    rnd_en = 0; rnd_busy = 0; fix_en = '0; resp = '0;
    for (int i = 0; i < NSRC; i++) begin dly[i] = 1; scnt[i] = 0; end
    #2;
    do_reset();

    // Round robin with every source enabled and answering
    resp = '1; fix_en = 4'hF; i_src_en = fix_en;
    for (int n = 0; n < 200 && inj_id.size() < 5; n++) step();
    chk("rr_count", inj_id.size(), 5);
    for (int k = 0; k < inj_id.size() && k < 5; k++) begin
      chk("rr_id", inj_id[k], rr_exp[k]);
      if (k > 0) chk("rr_spacing", inj_cyc[k] - inj_cyc[k-1], PIR + 3);
    end

    // Timeout: source 0 silent, source 2 answers
    do_reset();
    resp = 4'b1110; fix_en = 4'b0101; i_src_en = fix_en;
    n0 = 0; saw2 = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (!saw2 && o_src_send == 4'b0001) n0++;
      if (o_src_send == 4'b0100) saw2 = 1;
    end
    chk("tmo_window", n0, WIN);
    chk("tmo_next_grant", saw2, 1);
`ifdef ARB_STATS_EN
    chk("tmo_st_tmo", o_st_tmo, 1);
`endif

    // Illegal request from source 3 while source 1 holds the grant
    do_reset();
    resp = '1; dly[1] = 2; fix_en = 4'b0010; i_src_en = fix_en;
    step();
    chk("ill_granted", o_src_send, 4'b0010);
    i_src_req = i_src_req | 4'b1000;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin step(); got = o_net_req; end
    chk("ill_inject", got, 1);
    chk("ill_data_id", o_net_data[W-1:AB], 1);
`ifdef ARB_STATS_EN
    chk("ill_st_drop", o_st_drop, 1);
`endif
    dly[1] = 1;

    // Back-pressure held in IDLE, then released
    do_reset();
    resp = '1; fix_en = 4'hF; i_src_en = fix_en; i_net_busy = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      chk("bp_no_send", o_src_send, 0);
    end
    i_net_busy = 1'b0;
    step();
    chk("bp_grant", o_src_send, 4'b0001);

    // Reset in the middle of the gap, with 5 gap cycles still to go
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin step(); got = o_net_req; end
    chk("gap_inject", got, 1);
    repeat (PIR - 1 - 5) step();
    do_reset();
    i_src_en = fix_en;
    step();
    chk("rst_first_grant", o_src_send, 4'b0001);

    // Randomized traffic: enables, back-pressure, response delays up to beyond the window
    for (int b = 0; b < 6; b++) begin
      do_reset();
      resp = NSRC'($urandom_range(0, 15));
      for (int i = 0; i < NSRC; i++) dly[i] = $urandom_range(1, WIN);
      rnd_en = 1; rnd_busy = 1;
      i_src_en = NSRC'($urandom_range(0, 15));
      repeat (500) step();
    end
    rnd_en = 0; rnd_busy = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
